y86_execute_stage: RTL and testbench
====================================

Name: y86_execute_stage

Overview:
Execute stage of the Y86-64 sequential/pipelined datapath. It drives the existing 64-bit `alu` (control 00 add, 01 sub, 10 and, 11 xor) to produce valE, and owns the condition-code register (ZF/SF/OF). It evaluates the jXX/cmovXX condition and returns one registered result per accepted instruction over a valid/ready handshake. Sits between decode and memory stages.

Parameters:
WIDTH, 64, datapath width of valA/valB/valC/valE.
STACK_STEP, 8, byte adjustment for call/ret/push/pop.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
icode  input  4  Y86 icode (0 halt … B popq)
ifun  input  4  function/condition code
valA  input  WIDTH  operand A
valB  input  WIDTH  operand B
valC  input  WIDTH  constant
out_valid  output  1  result register holds valid data
out_ready  input  1  memory stage accepts result
out_icode  output  4  icode forwarded
out_valE  output  WIDTH  ALU result
out_valA  output  WIDTH  valA forwarded
out_cnd  output  1  condition outcome (jXX/cmovXX); 1 for other icodes
out_err  output  1  invalid icode, or invalid ifun for OPq/jXX/cmovXX
cc  output  3  {ZF,SF,OF} current register value
halted  output  1  stage in HALTED state

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_icode=0, out_valE=0, out_valA=0, out_cnd=0, out_err=0, cc={1,0,0}, halted=0, state=RUN. rst mid-transfer discards any held result.
- in_ready = (state==RUN) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Latency 1: on accept, the output register loads at the same edge; out_valid=1 the next cycle. Without accept and with out_ready=1, out_valid clears. With out_valid=1 and out_ready=0, all out_* hold stable.
- ALU drive, with a as the first operand: rrmovq/cmov a=valA,b=0 add; irmovq a=valC,b=0 add; rmmovq/mrmovq a=valB,b=valC add; OPq a=valB,b=valA, control=ifun[1:0]; call/pushq a=valB,b=STACK_STEP sub; ret/popq a=valB,b=STACK_STEP add; halt/nop/jXX valE=0.
- Arithmetic is modulo 2^WIDTH. OF is computed in-stage from operand signs, and the alu carry_overflow port is ignored:
  - add: OF = (a[63]==b[63]) && (r[63]!=a[63]).
  - sub: OF = (a[63]!=b[63]) && (r[63]!=a[63]).
  - and/xor: OF = 0.
- CC updates only on accept of OPq with ifun≤3: ZF=(r==0), SF=r[63], OF as above. No other icode touches CC.
- Condition uses the CC value before this edge's update, per ifun:
  - 0: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !(SF^OF)
  - 6 g: !(SF^OF)&!ZF
  - ifun>6: out_cnd=0, out_err=1.
- Invalid icode (>0xB) or OPq ifun>3: result passes with out_err=1, valE=0, CC unchanged.
- State machine:
  - RUN → HALTED on accept of icode 0 (the halt result itself is still emitted).
  - HALTED: in_ready=0, halted=1; the pending output still drains; exit only by rst.
- Back-to-back OPq → cmov: the second instruction sees the first instruction's CC, because the first updated CC at its accept edge.

Decomposition:
- Package y86_pkg: icode constants (I_HALT…I_POPQ), ALU control constants (ALU_ADD/SUB/AND/XOR), condition ifun constants, CC bit indices.
- One sub-module, y86_cond_eval: combinational {ZF,SF,OF}+ifun → cnd, bad_ifun.
- Existing `alu` is instantiated unchanged.

Test Plan:
- Reset then OPq add (ifun 0) with valA=3, valB=1 → out_valE=4, cc={0,0,0}, out_valid exactly 1 cycle after accept.
- OPq sub with valA=5897, valB=-123 → out_valE=-6020, cc={0,1,0}; then cmovl (ifun 2) → out_cnd=1; then cmovge → out_cnd=0.
- OPq add with valA=1, valB=0x7FFF_FFFF_FFFF_FFFF → out_valE=0x8000_0000_0000_0000, cc={0,1,1}; following jle → out_cnd=0.
- OPq xor with valA=valB=457869 → out_valE=0, cc={1,0,0}; pushq valB=0x100 → out_valE=0xF8, cc unchanged; jXX ifun=7 → out_err=1, out_cnd=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_* stable; out_ready=1 → next instruction accepted the same cycle and no result is lost or duplicated.
- Halt accepted → halt result emitted, halted=1, in_ready=0 thereafter despite in_valid=1; rst=1 → all outputs at reset values, cc={1,0,0}, in_ready=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared constants for the Y86-64 execute stage.
//   - icode values (I_HALT .. I_POPQ)
//   - ALU control encodings (add/sub/and/xor)
//   - condition codes carried in ifun for jXX/cmovXX
//   - bit positions of ZF/SF/OF inside the 3-bit cc vector {ZF,SF,OF}
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/alu.sv
// 64-bit (parameterisable) ALU used by the execute stage.
// Ports:
//   a, b            operands (result = a op b)
//   control         00 add, 01 sub (a - b), 10 and, 11 xor
//   result          WIDTH-bit result, modulo 2^WIDTH
//   carry_overflow  carry out of add / borrow of sub, 0 for logic ops
module alu #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] result,
  output logic             carry_overflow
);

  logic [WIDTH:0] wide;

  always_comb begin
    wide = '0;
    case (control)
      2'b00:   wide = {1'b0, a} + {1'b0, b};
      2'b01:   wide = {1'b0, a} - {1'b0, b};
      2'b10:   wide = {1'b0, a & b};
      default: wide = {1'b0, a ^ b};
    endcase
  end

  assign result         = wide[WIDTH-1:0];
  assign carry_overflow = wide[WIDTH];

endmodule

// File: rtl/y86_cond_eval.sv
// Combinational evaluation of the jXX/cmovXX condition.
// Ports:
//   cc        current {ZF,SF,OF}
//   ifun      condition selector (0 always .. 6 g)
//   cnd       condition outcome, 0 when ifun is not a defined condition
//   bad_ifun  ifun above 6
module y86_cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       bad_ifun
);

  logic zf, sf, of, lt;

  assign zf = cc[CC_ZF];
  assign sf = cc[CC_SF];
  assign of = cc[CC_OF];
  assign lt = sf ^ of;

  always_comb begin
    cnd      = 1'b0;
    bad_ifun = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  bad_ifun = 1'b1;
    endcase
  end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: drives the ALU to form valE, owns the condition
// code register, evaluates jXX/cmovXX conditions and hands one registered
// result per accepted instruction to the memory stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready = RUN && (!out_valid || out_ready), so a new result may
// replace the one being taken in the same cycle; while out_valid && !out_ready
// every out_* holds.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             decode -> execute handshake
//   icode, ifun, valA, valB, valC instruction fields from decode
//   out_valid/out_ready           execute -> memory handshake
//   out_icode, out_valE, out_valA registered result fields
//   out_cnd, out_err              condition outcome, invalid-instruction flag
//   cc                            {ZF,SF,OF} register
//   halted                        FSM is in HALTED (state debug view)
module y86_execute_stage
  import y86_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] out_valE,
  output logic [WIDTH-1:0] out_valA,
  output logic             out_cnd,
  output logic             out_err,
  output logic [2:0]       cc,
  output logic             halted
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  state_t state;

  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [1:0]       alu_ctl;
  logic             alu_carry_unused;  // OF is derived from operand signs instead
  logic             zero_vale;
  logic             of_next;
  logic             cnd_raw, bad_ifun;
  logic             icode_bad, opq_bad, uses_cond;
  logic             err_next, cnd_next, cc_update, accept;
  logic [WIDTH-1:0] vale_next;

  // Operand selection: a is always the first ALU operand.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_ctl   = ALU_ADD;
    zero_vale = 1'b0;
    case (icode)
      I_RRMOVQ: alu_a = valA;
      I_IRMOVQ: alu_a = valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = valB;
        alu_b = valC;
      end
      I_OPQ: begin
        alu_a   = valB;
        alu_b   = valA;
        alu_ctl = ifun[1:0];
      end
      I_CALL, I_PUSHQ: begin
        alu_a   = valB;
        alu_b   = STEP;
        alu_ctl = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        alu_a = valB;
        alu_b = STEP;
      end
      default: zero_vale = 1'b1;  // halt, nop, jXX, invalid icodes
    endcase
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a              (alu_a),
    .b              (alu_b),
    .control        (alu_ctl),
    .result         (alu_result),
    .carry_overflow (alu_carry_unused)
  );

  // Signed overflow from operand/result signs (sub is a - b).
  always_comb begin
    of_next = 1'b0;
    case (alu_ctl)
      ALU_ADD: of_next = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                         (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
      ALU_SUB: of_next = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                         (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
      default: of_next = 1'b0;
    endcase
  end

  // Condition uses the cc register as it stands before this edge.
  y86_cond_eval u_cond (
    .cc       (cc),
    .ifun     (ifun),
    .cnd      (cnd_raw),
    .bad_ifun (bad_ifun)
  );

  assign icode_bad = (icode > I_POPQ);
  assign opq_bad   = (icode == I_OPQ) && (ifun > 4'd3);
  assign uses_cond = (icode == I_RRMOVQ) || (icode == I_JXX);
  assign err_next  = icode_bad || opq_bad || (uses_cond && bad_ifun);
  assign cnd_next  = uses_cond ? cnd_raw : 1'b1;
  assign vale_next = (zero_vale || err_next) ? '0 : alu_result;
  assign cc_update = (icode == I_OPQ) && !opq_bad;

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign halted   = (state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      out_valid <= 1'b0;
      out_icode <= '0;
      out_valE  <= '0;
      out_valA  <= '0;
      out_cnd   <= 1'b0;
      out_err   <= 1'b0;
      cc        <= 3'b100;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_icode <= icode;
        out_valE  <= vale_next;
        out_valA  <= valA;
        out_cnd   <= cnd_next;
        out_err   <= err_next;
        if (cc_update) begin
          cc[CC_ZF] <= (alu_result == '0);
          cc[CC_SF] <= alu_result[WIDTH-1];
          cc[CC_OF] <= of_next;
        end
        if (icode == I_HALT) begin
          state <= S_HALTED;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed bench for y86_execute_stage with a queue-based scoreboard.
module tb_y86_execute_stage;

  localparam int W     = 64;
  localparam int EXP_W = 4 + W + W + 1 + 1 + 3;  // {icode,valE,valA,cnd,err,cc}

  typedef struct {
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] exp_vale;
    logic         exp_cnd;
    logic         exp_err;
    logic [2:0]   exp_cc;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA, valB, valC;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_icode;
  logic [W-1:0] out_valE;
  logic [W-1:0] out_valA;
  logic         out_cnd;
  logic         out_err;
  logic [2:0]   cc;
  logic         halted;

  logic [EXP_W-1:0] exp_q[$];
  vec_t             vecs[$];
  int               tests = 0;
  int               fails = 0;
  int               n_pushed = 0;
  int               n_popped = 0;

  y86_execute_stage #(.WIDTH(W), .STACK_STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA),
    .valB      (valB),
    .valC      (valC),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_icode (out_icode),
    .out_valE  (out_valE),
    .out_valA  (out_valA),
    .out_cnd   (out_cnd),
    .out_err   (out_err),
    .cc        (cc),
    .halted    (halted)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] e,
                              input logic cnd, input logic err, input logic [2:0] ccv);
    vec_t v;
    v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c;
    v.exp_vale = e; v.exp_cnd = cnd; v.exp_err = err; v.exp_cc = ccv;
    return v;
  endfunction

  // Driver: called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input vec_t v);
    int waited;
    waited   = 0;
    icode    = v.icode;
    ifun     = v.ifun;
    valA     = v.a;
    valB     = v.b;
    valC     = v.c;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        exp_q.push_back({v.icode, v.exp_vale, v.a, v.exp_cnd, v.exp_err, v.exp_cc});
        n_pushed++;
        break;
      end
      waited++;
      if (waited > 50) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: icode %h never accepted", v.icode);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e, act;
    if (!rst && out_valid && out_ready) begin
      act = {out_icode, out_valE, out_valA, out_cnd, out_err, cc};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: icode=%h valE=%h", out_icode, out_valE);
      end else begin
        e = exp_q.pop_front();
        n_popped++;
        if (act !== e) begin
          fails++;
          $display("FAIL result[%0d]: got icode=%h valE=%h valA=%h cnd=%b err=%b cc=%b, expected icode=%h valE=%h valA=%h cnd=%b err=%b cc=%b",
                   n_popped, act[136:133], act[132:69], act[68:5], act[4], act[3], act[2:0],
                   e[136:133], e[132:69], e[68:5], e[4], e[3], e[2:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int drain;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;

    // add / sub / overflow / cmov / jXX sequence, cc tracked by hand
    vecs.push_back(mk(4'h6, 4'h0, 64'd3, 64'd1, 64'd0, 64'd4, 1'b1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h6, 4'h1, 64'd5897, 64'hFFFF_FFFF_FFFF_FF85, 64'd0,
                      64'hFFFF_FFFF_FFFF_E87C, 1'b1, 1'b0, 3'b010));
    vecs.push_back(mk(4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 64'h55, 1'b1, 1'b0, 3'b010));
    vecs.push_back(mk(4'h2, 4'h5, 64'h66, 64'd0, 64'd0, 64'h66, 1'b0, 1'b0, 3'b010));
    vecs.push_back(mk(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,
                      64'h8000_0000_0000_0000, 1'b1, 1'b0, 3'b011));
    vecs.push_back(mk(4'h7, 4'h1, 64'd0, 64'd0, 64'h400, 64'd0, 1'b0, 1'b0, 3'b011));
    vecs.push_back(mk(4'h6, 4'h3, 64'd457869, 64'd457869, 64'd0, 64'd0, 1'b1, 1'b0, 3'b100));
    vecs.push_back(mk(4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 64'hF8, 1'b1, 1'b0, 3'b100));
    vecs.push_back(mk(4'h7, 4'h7, 64'd0, 64'd0, 64'h40, 64'd0, 1'b0, 1'b1, 3'b100));
    vecs.push_back(mk(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 64'd0, 1'b1, 1'b0, 3'b100));
    vecs.push_back(mk(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 64'h1234, 1'b1, 1'b0, 3'b100));
    vecs.push_back(mk(4'h4, 4'h0, 64'd0, 64'h1000, 64'h18, 64'h1018, 1'b1, 1'b0, 3'b100));
    vecs.push_back(mk(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 64'h100, 1'b1, 1'b0, 3'b100));
    vecs.push_back(mk(4'h9, 4'h0, 64'd0, 64'h200, 64'd0, 64'h208, 1'b1, 1'b0, 3'b100));
    vecs.push_back(mk(4'hC, 4'h0, 64'h99, 64'h5, 64'h6, 64'd0, 1'b1, 1'b1, 3'b100));
    vecs.push_back(mk(4'h6, 4'h4, 64'd1, 64'd1, 64'd0, 64'd0, 1'b1, 1'b1, 3'b100));
    vecs.push_back(mk(4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 64'h30, 1'b1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0,
                      64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'b001));
    vecs.push_back(mk(4'h7, 4'h2, 64'd0, 64'd0, 64'h80, 64'd0, 1'b1, 1'b0, 3'b001));
    vecs.push_back(mk(4'h7, 4'h6, 64'd0, 64'd0, 64'h80, 64'd0, 1'b0, 1'b0, 3'b001));
    vecs.push_back(mk(4'h2, 4'h0, 64'hABC, 64'd0, 64'd0, 64'hABC, 1'b1, 1'b0, 3'b001));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_cc", 64'(cc), 64'(3'b100));
    check("reset_halted", 64'(halted), 64'd0);
    check("reset_out_valE", out_valE, 64'd0);
    rst = 1'b0;

    // first instruction: out_valid exactly one cycle after accept
    send(vecs[0]);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    for (int i = 1; i < vecs.size(); i++) send(vecs[i]);

    // backpressure: result held for 3 cycles while next instruction waits
    send(mk(4'h3, 4'h0, 64'd0, 64'd0, 64'h5A5A, 64'h5A5A, 1'b1, 1'b0, 3'b001));
    out_ready = 1'b0;
    fork
      send(mk(4'h8, 4'h0, 64'd0, 64'h200, 64'd0, 64'h1F8, 1'b1, 1'b0, 3'b001));
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_out_valid", 64'(out_valid), 64'd1);
          check("bp_out_icode", 64'(out_icode), 64'h3);
          check("bp_out_valE", out_valE, 64'h5A5A);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join

    // halt: emitted, then no further accepts
    send(mk(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b001));
    check("halted_set", 64'(halted), 64'd1);
    icode = 4'h1; ifun = 4'h0; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("halt_in_ready", 64'(in_ready), 64'd0);
    end
    check("halt_drained", 64'(out_valid), 64'd0);
    in_valid = 1'b0;

    // reset out of HALTED
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_out_icode", 64'(out_icode), 64'd0);
    check("rst2_out_valA", out_valA, 64'd0);
    check("rst2_out_cnd", 64'(out_cnd), 64'd0);
    check("rst2_out_err", 64'(out_err), 64'd0);
    check("rst2_cc", 64'(cc), 64'(3'b100));
    check("rst2_halted", 64'(halted), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(mk(4'h6, 4'h0, 64'd2, 64'd2, 64'd0, 64'd4, 1'b1, 1'b0, 3'b000));

    // drain and final accounting
    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("pushed_eq_popped", 64'(n_popped), 64'(n_pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
